pwm12_decode: RTL and testbench

- Receive-side companion to the 12-bit PWM generator: measures an incoming PWM waveform and reports its high time and period in clk cycles.
- Used to close the loop on the motor-drive PWM outputs: self-test, duty readback, and detection of stuck (non-toggling) drive lines.
- Input is treated as asynchronous. It is synchronized, edge-detected and measured by a 3-state FSM.

---
 rtl/pwm12_decode.sv | 79 +++++++
 tb/tb_pwm12_decode.sv | 132 +++++++++++++
 2 files changed

// File: rtl/pwm12_decode.sv
// pwm12_decode: measures high time and rising-to-rising period of an asynchronous PWM input,
// and flags a line that stops toggling.
module pwm12_decode #(
  parameter logic [12:0] TIMEOUT = 13'h1FFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwm_in,
  output logic [11:0] duty,
  output logic [12:0] period,
  output logic        vld,
  output logic        stuck_hi,
  output logic        stuck_lo
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;
  logic [1:0]  sync_q, sync_d;
  logic        prev_q, prev_d;
  logic [1:0]  state_q, state_d;
  logic [11:0] high_cnt_q, high_cnt_d;
  logic [12:0] per_cnt_q, per_cnt_d;
  logic [11:0] duty_q, duty_d;
  logic [12:0] period_q, period_d;
  logic        vld_q, vld_d;
  logic        stuck_hi_q, stuck_hi_d;
  logic        stuck_lo_q, stuck_lo_d;
  logic        lvl, rise, fall, report, timeout;
  always_comb begin
    lvl        = sync_q[1];
    rise       = lvl & ~prev_q;
    fall       = ~lvl & prev_q;
    report     = rise & (state_q == LOW);
    // IDLE counts toward a timeout only until it has fired once
    timeout    = ~rise & (per_cnt_q == TIMEOUT) &
                 ((state_q != IDLE) | ~(stuck_hi_q | stuck_lo_q));
    sync_d     = {sync_q[0], pwm_in};
    prev_d     = lvl;
    state_d    = rise ? HIGH : timeout ? IDLE : (state_q == HIGH && fall) ? LOW : state_q;
    per_cnt_d  = rise ? 13'd1 : per_cnt_q + {12'd0, per_cnt_q != 13'h1FFF};
    high_cnt_d = rise ? 12'd1 :
                 high_cnt_q + {11'd0, (state_q == HIGH) & lvl & (high_cnt_q != 12'hFFF)};
    duty_d     = report ? high_cnt_q : timeout ? {12{lvl}} : duty_q;
    period_d   = report ? per_cnt_q : timeout ? 13'd0 : period_q;
    vld_d      = report | timeout;
    stuck_hi_d = ~rise & (stuck_hi_q | (timeout & lvl));
    stuck_lo_d = ~rise & (stuck_lo_q | (timeout & ~lvl));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      state_q    <= IDLE;
      high_cnt_q <= '0;
      per_cnt_q  <= '0;
      duty_q     <= '0;
      period_q   <= '0;
      vld_q      <= 1'b0;
      stuck_hi_q <= 1'b0;
      stuck_lo_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      state_q    <= state_d;
      high_cnt_q <= high_cnt_d;
      per_cnt_q  <= per_cnt_d;
      duty_q     <= duty_d;
      period_q   <= period_d;
      vld_q      <= vld_d;
      stuck_hi_q <= stuck_hi_d;
      stuck_lo_q <= stuck_lo_d;
    end
  end
  assign duty     = duty_q;
  assign period   = period_q;
  assign vld      = vld_q;
  assign stuck_hi = stuck_hi_q;
  assign stuck_lo = stuck_lo_q;
endmodule

// File: tb/tb_pwm12_decode.sv
// tb_pwm12_decode: two decoders (default and short timeout) share one random/directed PWM input;
// an edge-timestamp model queues expected reports that a per-cycle monitor checks.
module tb_pwm12_decode;
  logic clk = 0, rst_n = 0, pwm_in = 0;
  logic [11:0] duty_w [2];
  logic [12:0] period_w [2];
  logic vld_w [2], sh_w [2], sl_w [2];
  int checks = 0, failures = 0;
  typedef struct {int cyc; int duty; int period;} exp_t;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 50)
        $display("FAIL %s dut%0d time=%0t actual=%0d required=%0d", nm, d, $time, act, exp);
    end
  endtask
  task automatic chk_zero();
    for (int d = 0; d < 2; d++) begin
      chk("rst_duty", d, duty_w[d], 0);
      chk("rst_period", d, period_w[d], 0);
      chk("rst_vld", d, vld_w[d], 0);
      chk("rst_stuck_hi", d, sh_w[d], 0);
      chk("rst_stuck_lo", d, sl_w[d], 0);
    end
  endtask
  task automatic seg(input bit lv, input int n);
    pwm_in = lv;
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : u
    localparam int TO = (g == 0) ? 8191 : 100;
    pwm12_decode #(.TIMEOUT(13'(TO))) dut (
      .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .duty(duty_w[g]), .period(period_w[g]),
      .vld(vld_w[g]), .stuck_hi(sh_w[g]), .stuck_lo(sl_w[g])
    );
    exp_t q[$];
    int t = 0, t_rise = 0, t_fall = 0, ref_t = 0, hold_d = 0, hold_p = 0;
    bit prev = 0, meas = 0, seen_fall = 0, armed = 1, first = 1, sh = 0, sl = 0;
    bit sh_h [4], sl_h [4];
    // Model: sample index t is when pwm_in is captured; the DUT reacts 2 cycles later.
    always @(posedge clk) begin
      t++;
      if (!rst_n) begin
        q.delete();
        prev = 0; meas = 0; seen_fall = 0; armed = 1; first = 1; sh = 0; sl = 0;
        for (int i = 0; i < 4; i++) begin
          sh_h[i] = 0;
          sl_h[i] = 0;
        end
      end else begin
        if (first) begin
          ref_t = t - 2;
          first = 0;
        end
        if (pwm_in && !prev) begin
          if (meas && seen_fall)
            q.push_back('{t + 2, (t_fall - t_rise > 4095) ? 4095 : t_fall - t_rise, t - t_rise});
          sh = 0; sl = 0; t_rise = t; ref_t = t; meas = 1; seen_fall = 0; armed = 1;
        end else begin
          if (!pwm_in && prev && meas && !seen_fall) begin
            t_fall = t;
            seen_fall = 1;
          end
          if (armed && t - ref_t == TO) begin
            q.push_back('{t + 2, pwm_in ? 4095 : 0, 0});
            sh = pwm_in; sl = !pwm_in; meas = 0; armed = 0;
          end
        end
        prev = pwm_in;
        sh_h[t & 3] = sh;
        sl_h[t & 3] = sl;
      end
    end
    always @(negedge clk) begin
      if (!rst_n) begin
        hold_d = 0;
        hold_p = 0;
      end else begin
        if (q.size() != 0 && q[0].cyc == t) begin
          chk("vld_expected", g, vld_w[g], 1);
          chk("report_duty", g, duty_w[g], q[0].duty);
          chk("report_period", g, period_w[g], q[0].period);
          hold_d = q[0].duty;
          hold_p = q[0].period;
          void'(q.pop_front());
        end else begin
          chk("vld_idle", g, vld_w[g], 0);
          chk("duty_hold", g, duty_w[g], hold_d);
          chk("period_hold", g, period_w[g], hold_p);
        end
        chk("stuck_hi", g, sh_w[g], sh_h[(t - 2) & 3]);
        chk("stuck_lo", g, sl_w[g], sl_h[(t - 2) & 3]);
      end
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    #2;
    chk_zero();
    rst_n = 1;
    seg(0, 150);
    repeat (3) begin seg(1, 1); seg(0, 9); end
    repeat (3) begin seg(1, 9); seg(0, 1); end
    repeat (3) begin seg(1, 30); seg(0, 70); end
    seg(1, 30); seg(0, 71);
    seg(1, 30); seg(0, 70);
    repeat (40) begin
      seg(1, $urandom_range(1, 150));
      seg(0, $urandom_range(1, 150));
    end
    repeat (3) begin seg(0, 44); seg(1, 2004); seg(0, 2048); end
    seg(1, 5); seg(0, 8300);
    seg(1, 5); seg(0, 5); seg(1, 5); seg(0, 20);
    seg(1, 5000); seg(0, 10); seg(1, 3); seg(0, 3);
    seg(1, 20); seg(0, 20);
    seg(1, 20);
    rst_n = 0;
    #1;
    chk_zero();
    repeat (3) begin @(negedge clk); end
    #2;
    rst_n = 1;
    seg(1, 20); seg(0, 30); seg(1, 10); seg(0, 10); seg(1, 7); seg(0, 300);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
